// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard frame receiver feeding the LC-3 KBDR/KBSR registers.
// Valid/ready: kbd_ready holds kbd_data until kbd_ack (one-clock CPU read pulse) consumes it.
module ps2_kbd_rx #(
   parameter int TIMEOUT_CYC = 50000,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       kbd_ack,
   output logic [7:0] kbd_data,
   output logic       kbd_ready,
   output logic       parity_err,
   output logic       overrun
);

   localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DATA   = 2'd1,
      S_PARITY = 2'd2,
      S_STOP   = 2'd3
   } state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] data_sync;
   logic                   prev_clk;
   logic                   sync_clk;
   logic                   sync_data;
   logic                   fall;
   logic [2:0]             bit_cnt;
   logic [7:0]             shift_reg;
   logic                   par_bit;
   logic [TW-1:0]          to_cnt;
   logic                   timed_out;
   logic                   start_en;
   logic                   shift_en;
   logic                   par_en;
   logic                   frame_end;
   logic                   frame_good;
   logic                   frame_bad_par;

   // Synchronisers reset to the idle-high line level so reset never fakes an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_sync  <= '1;
         data_sync <= '1;
         prev_clk  <= 1'b1;
      end else begin
         clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
         data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
         prev_clk  <= sync_clk;
      end
   end

   assign sync_clk  = clk_sync[SYNC_STAGES-1];
   assign sync_data = data_sync[SYNC_STAGES-1];
   assign fall      = prev_clk & ~sync_clk;
   assign timed_out = (to_cnt == TW'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (fall) begin
         case (state)
            S_IDLE:   if (!sync_data) state_nxt = S_DATA;
            S_DATA:   if (bit_cnt == 3'd7) state_nxt = S_PARITY;
            S_PARITY: state_nxt = S_STOP;
            S_STOP:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
         endcase
      end else if (state != S_IDLE && timed_out) begin
         state_nxt = S_IDLE;
      end
   end

   always_comb begin
      start_en      = 1'b0;
      shift_en      = 1'b0;
      par_en        = 1'b0;
      frame_end     = 1'b0;
      case (state)
         S_IDLE:   start_en  = fall & ~sync_data;
         S_DATA:   shift_en  = fall;
         S_PARITY: par_en    = fall;
         S_STOP:   frame_end = fall;
         default:  ;
      endcase
      // Odd parity: the nine data+parity bits must XOR to 1.
      frame_good    = frame_end & sync_data & (^{shift_reg, par_bit});
      frame_bad_par = frame_end & sync_data & ~(^{shift_reg, par_bit});
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt   <= 3'd0;
         shift_reg <= 8'h00;
         par_bit   <= 1'b0;
         to_cnt    <= '0;
      end else begin
         if (start_en) begin
            bit_cnt   <= 3'd0;
            shift_reg <= 8'h00;
         end else if (shift_en) begin
            bit_cnt   <= bit_cnt + 3'd1;
            shift_reg <= {sync_data, shift_reg[7:1]};
         end else if (state != S_IDLE && timed_out) begin
            bit_cnt   <= 3'd0;
            shift_reg <= 8'h00;
         end
         if (par_en) begin
            par_bit <= sync_data;
         end
         if (state == S_IDLE || fall || timed_out) begin
            to_cnt <= '0;
         end else begin
            to_cnt <= to_cnt + 1'b1;
         end
      end
   end

   // A completing good frame takes precedence over a simultaneous ack.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         kbd_data   <= 8'h00;
         kbd_ready  <= 1'b0;
         parity_err <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         if (frame_good && (!kbd_ready || kbd_ack)) begin
            kbd_data  <= shift_reg;
            kbd_ready <= 1'b1;
         end else if (kbd_ack) begin
            kbd_ready <= 1'b0;
         end
         if (frame_bad_par) begin
            parity_err <= 1'b1;
         end else if (kbd_ack) begin
            parity_err <= 1'b0;
         end
         if (frame_good && kbd_ready && !kbd_ack) begin
            overrun <= 1'b1;
         end else if (kbd_ack) begin
            overrun <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx: PS/2 frames with hand-computed bytes, flags and timing.
module tb_ps2_kbd_rx;

   localparam int TIMEOUT = 1000;
   localparam int HALF    = 20;

   logic       clk;
   logic       rst_n;
   logic       ps2_clk;
   logic       ps2_data;
   logic       kbd_ack;
   logic [7:0] kbd_data;
   logic       kbd_ready;
   logic       parity_err;
   logic       overrun;

   int   tests;
   int   fails;
   logic rdy_pre;
   logic rdy_post;

   ps2_kbd_rx #(.TIMEOUT_CYC(TIMEOUT), .SYNC_STAGES(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .kbd_ack    (kbd_ack),
      .kbd_data   (kbd_data),
      .kbd_ready  (kbd_ready),
      .parity_err (parity_err),
      .overrun    (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Frame bits LSB first: start, 8 data, parity, stop.
   function automatic logic [10:0] mk(input logic [7:0] d, input logic par, input logic stp);
      return {stp, par, d, 1'b0};
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_bits(input logic [10:0] f, input int first, input int last);
      for (int i = first; i <= last; i++) begin
         ps2_data = f[i];
         repeat (HALF) @(negedge clk);
         ps2_clk = 1'b0;
         repeat (HALF) @(negedge clk);
         ps2_clk = 1'b1;
      end
   endtask

   // Full frame; the stop-bit fall is traced cycle by cycle and ack can land on completion.
   task automatic send_frame(input logic [10:0] f, input logic ack_last);
      send_bits(f, 0, 9);
      ps2_data = f[10];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rdy_pre = kbd_ready;
      kbd_ack = ack_last;
      @(negedge clk);
      rdy_post = kbd_ready;
      kbd_ack  = 1'b0;
      repeat (HALF - 3) @(negedge clk);
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      repeat (40) @(negedge clk);
   endtask

   task automatic ack_pulse();
      @(negedge clk);
      kbd_ack = 1'b1;
      @(negedge clk);
      kbd_ack = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      tests    = 0;
      fails    = 0;
      rst_n    = 1'b0;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      kbd_ack  = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_data", kbd_data, 8'h00);
      check("rst_ready", {7'd0, kbd_ready}, 8'd0);
      check("rst_perr", {7'd0, parity_err}, 8'd0);
      check("rst_ovr", {7'd0, overrun}, 8'd0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // 0x1C, three ones -> parity 0; ready must appear one clk after the fall is seen.
      send_frame(mk(8'h1C, 1'b0, 1'b1), 1'b0);
      check("t1_ready_pre", {7'd0, rdy_pre}, 8'd0);
      check("t1_ready_post", {7'd0, rdy_post}, 8'd1);
      check("t1_data", kbd_data, 8'h1C);
      check("t1_perr", {7'd0, parity_err}, 8'd0);
      ack_pulse();
      check("t1_ack_ready", {7'd0, kbd_ready}, 8'd0);

      // 0xF0, four ones -> parity 1.
      send_frame(mk(8'hF0, 1'b1, 1'b1), 1'b0);
      check("t2_data", kbd_data, 8'hF0);
      check("t2_ready", {7'd0, kbd_ready}, 8'd1);
      ack_pulse();
      check("t2_ack_ready", {7'd0, kbd_ready}, 8'd0);
      check("t2_ack_data", kbd_data, 8'hF0);

      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("t3_rst_data", kbd_data, 8'h00);
      repeat (5) @(negedge clk);

      // 0x1C with parity forced to 1 -> even total, rejected.
      send_frame(mk(8'h1C, 1'b1, 1'b1), 1'b0);
      check("t3_perr", {7'd0, parity_err}, 8'd1);
      check("t3_ready", {7'd0, kbd_ready}, 8'd0);
      check("t3_data", kbd_data, 8'h00);
      ack_pulse();
      check("t3_ack_perr", {7'd0, parity_err}, 8'd0);

      // Overrun: second good byte while the first is unread.
      send_frame(mk(8'h1C, 1'b0, 1'b1), 1'b0);
      send_frame(mk(8'h32, 1'b0, 1'b1), 1'b0);
      check("t4_data", kbd_data, 8'h1C);
      check("t4_ovr", {7'd0, overrun}, 8'd1);
      check("t4_ready", {7'd0, kbd_ready}, 8'd1);
      ack_pulse();
      check("t4_ack_ready", {7'd0, kbd_ready}, 8'd0);
      check("t4_ack_ovr", {7'd0, overrun}, 8'd0);

      // Partial frame abandoned by timeout, then a clean 0x5A (four ones -> parity 1).
      send_bits(mk(8'h5A, 1'b1, 1'b1), 0, 4);
      repeat (TIMEOUT + 20) @(negedge clk);
      check("t5_idle_ready", {7'd0, kbd_ready}, 8'd0);
      send_frame(mk(8'h5A, 1'b1, 1'b1), 1'b0);
      check("t5_data", kbd_data, 8'h5A);
      check("t5_ready", {7'd0, kbd_ready}, 8'd1);
      check("t5_perr", {7'd0, parity_err}, 8'd0);
      check("t5_ovr", {7'd0, overrun}, 8'd0);

      // Async reset in the middle of a 0x1C frame; the frame tail is junk.
      send_bits(mk(8'h1C, 1'b0, 1'b1), 0, 3);
      ps2_data = 1'b1;
      repeat (10) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("t6_async_data", kbd_data, 8'h00);
      check("t6_async_ready", {7'd0, kbd_ready}, 8'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
      send_bits(mk(8'h1C, 1'b0, 1'b1), 5, 10);
      ps2_data = 1'b1;
      repeat (TIMEOUT + 20) @(negedge clk);
      check("t6_junk_ready", {7'd0, kbd_ready}, 8'd0);
      check("t6_junk_perr", {7'd0, parity_err}, 8'd0);
      check("t6_junk_data", kbd_data, 8'h00);
      // 0x29, three ones -> parity 0.
      send_frame(mk(8'h29, 1'b0, 1'b1), 1'b0);
      check("t6_data", kbd_data, 8'h29);
      check("t6_ready", {7'd0, kbd_ready}, 8'd1);

      // Ack coinciding with a good completion: new byte wins, no overrun.
      send_frame(mk(8'h1C, 1'b0, 1'b1), 1'b1);
      check("t7_data", kbd_data, 8'h1C);
      check("t7_ready", {7'd0, kbd_ready}, 8'd1);
      check("t7_ovr", {7'd0, overrun}, 8'd0);

      // Bad stop bit: discarded, no flags even though a byte is pending.
      send_frame(mk(8'h32, 1'b0, 1'b0), 1'b0);
      check("t8_data", kbd_data, 8'h1C);
      check("t8_ovr", {7'd0, overrun}, 8'd0);
      check("t8_perr", {7'd0, parity_err}, 8'd0);
      check("t8_ready", {7'd0, kbd_ready}, 8'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ps2_kbd_rx.md
Name: ps2_kbd_rx

Overview:
- PS/2 frame receiver; consumes the serial keyboard stream (ps2_clk/ps2_data) and produces one byte per frame for the LC-3 keyboard device registers (KBDR/KBSR).
- Synchronises both PS/2 lines into the system clock domain and detects ps2_clk falling edges.
- Deserialises 11-bit frames: start 0, 8 data bits LSB first, odd parity, stop 1.
- Holds the byte with a ready flag until the CPU acknowledges by reading KBDR.

Parameters:
- TIMEOUT_CYC, 50000, system clocks with no ps2_clk falling edge before a partial frame is abandoned.
- SYNC_STAGES, 2, flip-flop stages on ps2_clk and ps2_data (must be 2 or more).

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ps2_clk  input  1  PS/2 clock line, asynchronous; idles high.
- ps2_data  input  1  PS/2 data line, asynchronous; idles high.
- kbd_ack  input  1  one-clock pulse when the CPU reads KBDR; clears kbd_ready.
- kbd_data  output  8  last accepted byte (KBDR[7:0]).
- kbd_ready  output  1  byte available (KBSR[15]).
- parity_err  output  1  sticky; set when a frame fails the parity check.
- overrun  output  1  sticky; set when a good frame completes while kbd_ready=1.

Behaviour:
- Reset values:
  - kbd_data=0x00; kbd_ready=0; parity_err=0; overrun=0.
  - FSM=IDLE; bit counter=0; timeout counter=0.
  - Synchroniser flops=1 (idle level).
- Edge detect:
  - fall = prev_sync_clk & ~sync_clk.
  - sync_data is sampled in the same clk cycle that fall=1.
  - Only fall events advance the FSM.
- FSM:
  - IDLE:
    - fall with data=0: go to DATA; bit counter=0.
    - fall with data=1: glitch; stay in IDLE.
  - DATA:
    - on each fall, shift data in at bit [7] with a right shift, so the first bit received ends at [0].
    - After the 8th bit, go to PARITY.
  - PARITY:
    - on fall, latch the parity bit; go to STOP.
  - STOP:
    - on fall, evaluate the frame; go to IDLE.
    - Good frame = stop bit 1 and odd total of (8 data + parity) ones.
- Frame outcome, registered in the cycle after the stop-bit fall (latency 1 clk):
  - Good frame, kbd_ready=0: kbd_data updated; kbd_ready=1.
  - Good frame, kbd_ready=1: kbd_data unchanged (old byte kept); overrun=1.
  - Bad parity: parity_err=1; kbd_data and kbd_ready unchanged.
  - Bad stop bit (stop=0): frame discarded silently; no flags change.
- kbd_ack:
  - kbd_ready clears on the next clk.
  - Clears parity_err and overrun in the same cycle.
  - If kbd_ack and a good-frame completion occur in the same cycle, completion wins: kbd_data=new byte, kbd_ready stays 1, overrun not set.
- Timeout:
  - Counter runs while not in IDLE and resets on every fall.
  - Reaching TIMEOUT_CYC-1 forces IDLE and discards the partial byte; no flags change.
  - Counter is held at 0 in IDLE.
- Async reset mid-frame: everything returns to reset values immediately. The remaining bits of that frame are treated as glitches or junk until a timeout or the next valid start bit.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- Frame 0x1C (bits 0,0,0,1,1,1,0,0,0, parity 0, stop 1), ps2 bit period 40 clk -> kbd_ready=1 exactly 1 clk after the stop-bit fall is seen; kbd_data=0x1C; parity_err=0.
- Frame 0xF0 with parity 1, then kbd_ack pulse -> kbd_data=0xF0, kbd_ready=1. After the ack: kbd_ready=0, kbd_data stays 0xF0.
- Frame 0x1C with parity forced to 1 -> parity_err=1, kbd_ready=0, kbd_data=0x00. A following kbd_ack clears parity_err.
- Send 0x1C, no ack, then send 0x32 -> kbd_data=0x1C, overrun=1. Ack -> kbd_ready=0, overrun=0.
- Send 5 bits of a frame, idle for TIMEOUT_CYC clks, then a full 0x5A frame -> kbd_data=0x5A, no error flags.
- Assert rst_n=0 for 3 clk mid-data of a 0x1C frame -> all outputs 0 asynchronously. Then a full 0x29 frame (after timeout) -> kbd_data=0x29.
